// File: rtl/argmax_stream_driver.sv
// Buffers one score vector, streams it into the argmax cell chain as indexed beats,
// then captures the returned winner and offers it downstream with a valid/ready handshake.
module argmax_stream_driver #(
    parameter int DATA_WIDTH     = 32,
    parameter int CELL_AMOUNT    = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] score_value,
    input  logic                  score_valid,
    output logic                  score_ready,
    output logic [DATA_WIDTH-1:0] cell_index,
    output logic [DATA_WIDTH-1:0] cell_value,
    output logic                  cell_enable,
    input  logic [DATA_WIDTH:0]   cell_result,
    output logic [DATA_WIDTH-1:0] class_index,
    output logic                  class_valid,
    input  logic                  class_ready,
    output logic                  busy,
    output logic                  timeout_error,
    output logic [1:0]            state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the presented data holds until the transfer.

    localparam int IDX_W = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
    localparam int PTR_W = $clog2(CELL_AMOUNT + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_AMOUNT - 1);
    localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(CELL_AMOUNT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [TMR_W-1:0]      timer;
    logic [DATA_WIDTH-1:0] score_buf [2**IDX_W];

    assign score_ready = (state == LOAD);
    assign busy        = (state != LOAD);
    assign state_dbg   = state;

    // Storage is deliberately left out of reset; a reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && score_valid) begin
            score_buf[wr_ptr] <= score_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            timer         <= '0;
            cell_enable   <= 1'b0;
            cell_index    <= '0;
            cell_value    <= '0;
            class_valid   <= 1'b0;
            class_index   <= '0;
            timeout_error <= 1'b0;
        end else begin
            timeout_error <= 1'b0;
            case (state)
                LOAD: begin
                    if (score_valid) begin
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr <= '0;
                            state  <= STREAM;
                        end else begin
                            wr_ptr <= wr_ptr + IDX_W'(1);
                        end
                    end
                end
                STREAM: begin
                    // One beat per cycle; the extra cycle after the last beat drops enable.
                    if (rd_ptr == END_PTR) begin
                        cell_enable <= 1'b0;
                        cell_index  <= '0;
                        cell_value  <= '0;
                        rd_ptr      <= '0;
                        timer       <= '0;
                        state       <= WAIT;
                    end else begin
                        cell_enable <= 1'b1;
                        cell_index  <= DATA_WIDTH'(rd_ptr);
                        cell_value  <= score_buf[rd_ptr[IDX_W-1:0]];
                        rd_ptr      <= rd_ptr + PTR_W'(1);
                    end
                end
                WAIT: begin
                    // The result valid is a one-cycle pulse, so it wins over a same-cycle timeout.
                    if (cell_result[DATA_WIDTH]) begin
                        class_index <= cell_result[DATA_WIDTH-1:0];
                        class_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (timer == TMR_LAST) begin
                        timeout_error <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                HOLD: begin
                    if (class_ready) begin
                        class_valid <= 1'b0;
                        state       <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream_driver.sv
// Scoreboard bench for argmax_stream_driver: directed score vectors, a stub/model responder
// standing in for the argmax chain, and monitors that pop expected beats and classes.
module tb_argmax_stream_driver;
    localparam int W  = 32;
    localparam int CA = 4;
    localparam int TO = 8;

    typedef logic [W-1:0] vec_t [CA];

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  score_value;
    logic          score_valid;
    logic          score_ready;
    logic [W-1:0]  cell_index;
    logic [W-1:0]  cell_value;
    logic          cell_enable;
    logic [W:0]    cell_result;
    logic [W-1:0]  class_index;
    logic          class_valid;
    logic          class_ready;
    logic          busy;
    logic          timeout_error;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] exp_beat_q[$];
    logic [W-1:0]   exp_q[$];

    int           resp_mode  = 0;  // 0 silent, 1 fixed stub index, 2 argmax model
    int           resp_extra = 0;  // idle cycles beyond the two-cycle response
    logic [W-1:0] stub_idx   = '0;
    bit           abort_run  = 1'b0;

    argmax_stream_driver #(
        .DATA_WIDTH(W),
        .CELL_AMOUNT(CA),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .score_value(score_value),
        .score_valid(score_valid),
        .score_ready(score_ready),
        .cell_index(cell_index),
        .cell_value(cell_value),
        .cell_enable(cell_enable),
        .cell_result(cell_result),
        .class_index(class_index),
        .class_valid(class_valid),
        .class_ready(class_ready),
        .busy(busy),
        .timeout_error(timeout_error),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat monitor: every enabled cycle must match the next expected (index, value).
    initial begin
        int run_len = 0;
        forever begin
            @(negedge clk);
            if (cell_enable) begin
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_beat", {cell_index, cell_value}, '0);
                end else begin
                    check("beat", {cell_index, cell_value}, exp_beat_q.pop_front());
                end
                run_len++;
            end else if (run_len > 0) begin
                if (!abort_run) check("beat_run_length", 64'(run_len), 64'(CA));
                abort_run = 1'b0;
                run_len   = 0;
            end
        end
    end

    // Class monitor: each new class_valid presentation pops one expected index.
    initial begin
        logic prev_cv = 1'b0;
        forever begin
            @(negedge clk);
            if (class_valid && !prev_cv) begin
                if (exp_q.size() == 0) check("unexpected_class", 64'(class_index), '1);
                else check("class_index", 64'(class_index), 64'(exp_q.pop_front()));
            end
            prev_cv = class_valid;
        end
    end

    // Responder standing in for the argmax chain: pulses the result valid after the stream ends.
    initial begin
        bit           seen     = 1'b0;
        int           resp_cnt = -1;
        logic [W-1:0] best_val = '0;
        logic [W-1:0] best_idx = '0;
        cell_result = '0;
        forever begin
            @(negedge clk);
            cell_result = '0;
            if (resp_cnt == 0) begin
                cell_result = {1'b1, (resp_mode == 1) ? stub_idx : best_idx};
                resp_cnt    = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            if (cell_enable) begin
                if (!seen || cell_value > best_val) begin
                    best_val = cell_value;
                    best_idx = cell_index;
                end
                seen = 1'b1;
            end else if (seen) begin
                seen = 1'b0;
                if (resp_mode != 0) resp_cnt = resp_extra;
            end
        end
    end

    task automatic load_vec(input vec_t v, input bit gaps);
        int i  = 0;
        bit ph = 1'b0;
        while (i < CA) begin
            @(negedge clk);
            if (gaps && ph) begin
                score_valid = 1'b0;
                score_value = 32'hdead_beef;
            end else begin
                score_valid = 1'b1;
                score_value = v[i];
                i++;
            end
            ph = !ph;
        end
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic push_beats(input vec_t v, input int count);
        for (int i = 0; i < count; i++) exp_beat_q.push_back({32'(i), v[i]});
    endtask

    task automatic wait_class(output int n);
        n = 0;
        while (!class_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!class_valid) check("class_valid_timeout", 64'(class_valid), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   pulses;
        int   pulse_at;
        bit   cv_seen;

        rst = 1'b1; score_value = '0; score_valid = 1'b0; class_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_score_ready", 64'(score_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cell_enable", 64'(cell_enable), 64'd0);
        check("rst_cell_bus", {cell_index, cell_value}, '0);
        check("rst_class_valid", 64'(class_valid), 64'd0);
        check("rst_class_index", 64'(class_index), 64'd0);
        check("rst_timeout", 64'(timeout_error), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b0;

        // Gap-free load, stub answers index 1, class held with class_ready low.
        v = '{32'd5, 32'd9, 32'd2, 32'd7};
        resp_mode = 1; stub_idx = 32'd1; resp_extra = 0;
        push_beats(v, CA);
        exp_q.push_back(32'd1);
        load_vec(v, 1'b0);
        check("stream_score_ready", 64'(score_ready), 64'd0);
        check("stream_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("first_beat_enable", 64'(cell_enable), 64'd1);
        n = 1;
        while (!class_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("class_latency", 64'(n), 64'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(class_valid), 64'd1);
            check("hold_index", 64'(class_index), 64'd1);
        end
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        check("release_valid", 64'(class_valid), 64'd0);
        check("release_score_ready", 64'(score_ready), 64'd1);

        // Same vector with score_valid toggling; class_ready high even before a class exists.
        stub_idx = 32'd2; resp_extra = 3;
        class_ready = 1'b1;
        push_beats(v, CA);
        exp_q.push_back(32'd2);
        load_vec(v, 1'b1);
        wait_class(n);
        check("gap_class_latency", 64'(n), 64'd10);
        @(negedge clk);
        check("gap_consumed", 64'(class_valid), 64'd0);
        check("gap_score_ready", 64'(score_ready), 64'd1);

        // Back-to-back vectors through the argmax model.
        resp_mode = 2; resp_extra = 0;
        v = '{32'd2, 32'd1, 32'd0, 32'd0};
        push_beats(v, CA); exp_q.push_back(32'd0);
        load_vec(v, 1'b0);
        wait_class(n);
        v = '{32'd3, 32'd6, 32'd1, 32'd4};
        push_beats(v, CA); exp_q.push_back(32'd1);
        load_vec(v, 1'b0);
        wait_class(n);
        v = '{32'd1, 32'd2, 32'd3, 32'd9};
        push_beats(v, CA); exp_q.push_back(32'd3);
        load_vec(v, 1'b0);
        wait_class(n);
        @(negedge clk);
        class_ready = 1'b0;

        // Silent responder: exactly one timeout pulse after TO cycles in WAIT.
        resp_mode = 0;
        v = '{32'd4, 32'd3, 32'd2, 32'd1};
        push_beats(v, CA);
        load_vec(v, 1'b0);
        pulses = 0; pulse_at = 0; cv_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (timeout_error) begin
                pulses++;
                pulse_at = k;
            end
            if (class_valid) cv_seen = 1'b1;
        end
        check("timeout_pulses", 64'(pulses), 64'd1);
        check("timeout_position", 64'(pulse_at), 64'd13);
        check("timeout_no_class", 64'(cv_seen), 64'd0);
        check("timeout_back_to_load", 64'(score_ready), 64'd1);

        // Reset in the middle of the stream, then a fresh vector from index 0.
        v = '{32'd8, 32'd7, 32'd6, 32'd5};
        abort_run = 1'b1;
        push_beats(v, 2);
        load_vec(v, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cell_enable", 64'(cell_enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_score_ready", 64'(score_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        resp_mode = 1; stub_idx = 32'd3; resp_extra = 0;
        v = '{32'd1, 32'd2, 32'd3, 32'd4};
        push_beats(v, CA); exp_q.push_back(32'd3);
        load_vec(v, 1'b0);
        wait_class(n);
        check("fresh_class_latency", 64'(n), 64'd7);
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        check("fresh_release", 64'(class_valid), 64'd0);

        repeat (4) @(negedge clk);
        check("beats_drained", 64'(exp_beat_q.size()), 64'd0);
        check("classes_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
